// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one MAIN_MEMORY port between fetch (port 0) and data (port 1),
// with RD/WRMain/ACK sequencing and an ACK timeout that aborts a hung access.
module mem_arbiter #(
   parameter int DATAWIDTH_BUS  = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TIMER_WIDTH    = 5
) (
   input  logic                     MEM_ARBITER_CLOCK_50,
   input  logic                     MEM_ARBITER_ResetInLow_In,
   input  logic [1:0]               MEM_ARBITER_Req_InBus,
   input  logic [1:0]               MEM_ARBITER_Wr_InBus,
   input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_Addr0_InBus,
   input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_Addr1_InBus,
   input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_WData1_InBus,
   output logic [1:0]               MEM_ARBITER_Done_OutBus,
   output logic                     MEM_ARBITER_Err_Out,
   output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_RData_OutBus,
   output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MemA_OutBus,
   output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MemB_OutBus,
   output logic                     MEM_ARBITER_RD_Out,
   output logic                     MEM_ARBITER_WRMain_Out,
   input  logic                     MEM_ARBITER_ACK_In,
   input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MemData_InBus
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
   state_t                   r_state, w_state_nx;
   logic                     r_last, w_last_nx, r_win, w_win_nx, w_pick;
   logic [TIMER_WIDTH-1:0]   r_timer, w_timer_nx;
   logic                     r_rd, w_rd_nx, r_wr, w_wr_nx, r_err, w_err_nx;
   logic [1:0]               r_done, w_done_nx;
   logic [DATAWIDTH_BUS-1:0] r_rdata, w_rdata_nx, r_mema, w_mema_nx, r_memb, w_memb_nx;
   // On a tie the port that did not win last time is granted; port 0 can only read.
   assign w_pick = (MEM_ARBITER_Req_InBus == 2'b11) ? ~r_last : MEM_ARBITER_Req_InBus[1];
   always_comb begin
      w_state_nx = r_state;
      w_last_nx  = r_last;
      w_win_nx   = r_win;
      w_timer_nx = r_timer;
      w_rd_nx    = r_rd;
      w_wr_nx    = r_wr;
      w_err_nx   = 1'b0;
      w_done_nx  = 2'b00;
      w_rdata_nx = r_rdata;
      w_mema_nx  = r_mema;
      w_memb_nx  = r_memb;
      case (r_state)
         S_IDLE: if (|MEM_ARBITER_Req_InBus) begin
            w_state_nx = S_ACCESS;
            w_last_nx  = w_pick;
            w_win_nx   = w_pick;
            w_timer_nx = '0;
            w_wr_nx    = w_pick & MEM_ARBITER_Wr_InBus[w_pick];
            w_rd_nx    = ~(w_pick & MEM_ARBITER_Wr_InBus[w_pick]);
            w_mema_nx  = w_pick ? MEM_ARBITER_Addr1_InBus : MEM_ARBITER_Addr0_InBus;
            w_memb_nx  = w_pick ? MEM_ARBITER_WData1_InBus : r_memb;
         end
         S_ACCESS: begin
            w_timer_nx = r_timer + 1'b1;
            // ACK takes priority over the timeout on the limit cycle.
            if (MEM_ARBITER_ACK_In || r_timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               w_state_nx = S_DONE;
               w_rd_nx    = 1'b0;
               w_wr_nx    = 1'b0;
               w_done_nx  = r_win ? 2'b10 : 2'b01;
               w_err_nx   = ~MEM_ARBITER_ACK_In;
               w_rdata_nx = !MEM_ARBITER_ACK_In ? '0 : r_wr ? r_rdata : MEM_ARBITER_MemData_InBus;
            end
         end
         S_DONE: begin
            w_state_nx = S_IDLE;
            w_timer_nx = '0;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge MEM_ARBITER_CLOCK_50 or negedge MEM_ARBITER_ResetInLow_In)
      if (!MEM_ARBITER_ResetInLow_In) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_win   <= 1'b0;
         r_timer <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_err   <= 1'b0;
         r_done  <= 2'b00;
         r_rdata <= '0;
         r_mema  <= '0;
         r_memb  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_last  <= w_last_nx;
         r_win   <= w_win_nx;
         r_timer <= w_timer_nx;
         r_rd    <= w_rd_nx;
         r_wr    <= w_wr_nx;
         r_err   <= w_err_nx;
         r_done  <= w_done_nx;
         r_rdata <= w_rdata_nx;
         r_mema  <= w_mema_nx;
         r_memb  <= w_memb_nx;
      end
   assign MEM_ARBITER_Done_OutBus  = r_done;
   assign MEM_ARBITER_Err_Out      = r_err;
   assign MEM_ARBITER_RData_OutBus = r_rdata;
   assign MEM_ARBITER_MemA_OutBus  = r_mema;
   assign MEM_ARBITER_MemB_OutBus  = r_memb;
   assign MEM_ARBITER_RD_Out       = r_rd;
   assign MEM_ARBITER_WRMain_Out   = r_wr;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, hand sequences and random transactions checked against
// a transaction-level model of the arbiter.
module tb_mem_arbiter;
   localparam int DW = 32;
   logic          clk = 1'b0, rst_n = 1'b0, ack = 1'b0;
   logic [1:0]    req = 2'b00, wr = 2'b00;
   logic [DW-1:0] a0 = '0, a1 = '0, wd = '0, md = '0;
   logic [1:0]    done;
   logic          err, rd, wrm;
   logic [DW-1:0] rdata, mema, memb;
   always #5 clk = ~clk;
   mem_arbiter #(.DATAWIDTH_BUS(DW), .TIMEOUT_CYCLES(16), .TIMER_WIDTH(5)) dut (
      .MEM_ARBITER_CLOCK_50(clk), .MEM_ARBITER_ResetInLow_In(rst_n),
      .MEM_ARBITER_Req_InBus(req), .MEM_ARBITER_Wr_InBus(wr),
      .MEM_ARBITER_Addr0_InBus(a0), .MEM_ARBITER_Addr1_InBus(a1),
      .MEM_ARBITER_WData1_InBus(wd), .MEM_ARBITER_Done_OutBus(done),
      .MEM_ARBITER_Err_Out(err), .MEM_ARBITER_RData_OutBus(rdata),
      .MEM_ARBITER_MemA_OutBus(mema), .MEM_ARBITER_MemB_OutBus(memb),
      .MEM_ARBITER_RD_Out(rd), .MEM_ARBITER_WRMain_Out(wrm),
      .MEM_ARBITER_ACK_In(ack), .MEM_ARBITER_MemData_InBus(md));
   int n_chk = 0, n_fail = 0;
   logic after_done = 1'b0;
   logic m_last = 1'b1;
   logic [DW-1:0] m_rdata = '0;
   logic [1:0] t_done;
   logic t_err, t_stable;
   logic [DW-1:0] t_rdata, t_mema, t_memb;
   int t_rd, t_wr, t_lat;
   typedef struct {
      logic [1:0] req; logic w1; logic [DW-1:0] a0, a1, wd, md; int ack_at;
      logic [1:0] e_done; logic e_err; logic [DW-1:0] e_rdata; int e_rd, e_wr; logic [DW-1:0] e_mema;
   } vec_t;
   vec_t tbl[7];
   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic idle(input int n);
      repeat (n) tick();
      after_done = 1'b0;
   endtask
   // Drives one request and plays memory: ACK on the ack_at-th strobe cycle (0 = never).
   task automatic run_txn(input logic [1:0] r, input logic w1, input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                          input logic [DW-1:0] xd, input int ack_at, input logic [DW-1:0] xm);
      int cyc, s;
      req = r; wr = {w1, 1'b1}; a0 = x0; a1 = x1; wd = xd; md = xm; ack = 1'b0;
      t_done = 2'b00; t_err = 1'b0; t_rdata = '0; t_rd = 0; t_wr = 0; t_lat = 0;
      t_stable = 1'b1; t_mema = '0; t_memb = '0; cyc = 0; s = 0;
      if (after_done) tick();
      while (t_done == 2'b00 && cyc < 60) begin
         tick();
         cyc++;
         if (rd | wrm) begin
            s++;
            t_rd += int'(rd);
            t_wr += int'(wrm);
            if (s == 1) begin
               t_mema = mema; t_memb = memb;
               a0 = ~x0; a1 = ~x1; wd = ~xd; wr = ~wr;
            end else if (mema !== t_mema || memb !== t_memb) t_stable = 1'b0;
            ack = (s == ack_at);
         end else ack = 1'b0;
         if (done != 2'b00) begin
            t_done = done; t_err = err; t_rdata = rdata; t_lat = cyc;
         end
      end
      ack = 1'b0;
      after_done = 1'b1;
      chk("txn_completed", DW'(t_done != 2'b00), DW'(1));
   endtask
   task automatic check_txn(input string nm, input logic [1:0] e_done, input logic e_err, input logic [DW-1:0] e_rdata,
                            input int e_rd, input int e_wr, input logic [DW-1:0] e_mema, input logic [DW-1:0] e_memb);
      chk({nm, ".done"}, DW'(t_done), DW'(e_done));
      chk({nm, ".err"}, DW'(t_err), DW'(e_err));
      chk({nm, ".rdata"}, t_rdata, e_rdata);
      chk({nm, ".rd_cycles"}, DW'(t_rd), DW'(e_rd));
      chk({nm, ".wr_cycles"}, DW'(t_wr), DW'(e_wr));
      chk({nm, ".mema"}, t_mema, e_mema);
      if (e_wr > 0) chk({nm, ".memb"}, t_memb, e_memb);
      chk({nm, ".stable"}, DW'(t_stable), DW'(1));
      chk({nm, ".latency"}, DW'(t_lat), DW'(e_rd + e_wr + 1));
   endtask
   function automatic logic pick(input logic [1:0] r);
      if (r == 2'b11) return !m_last;
      return r[1];
   endfunction
   // Model a transaction from the rules: grant, strobe length, error and read data.
   task automatic model_txn(input string nm, input logic [1:0] r, input logic w1, input logic [DW-1:0] x0,
                            input logic [DW-1:0] x1, input logic [DW-1:0] xd, input int ack_at, input logic [DW-1:0] xm);
      logic p, w, e;
      int n;
      p = pick(r);
      w = p & w1;
      e = !(ack_at >= 1 && ack_at <= 16);
      n = e ? 16 : ack_at;
      run_txn(r, w1, x0, x1, xd, ack_at, xm);
      m_last = p;
      m_rdata = e ? '0 : (w ? m_rdata : xm);
      check_txn(nm, p ? 2'b10 : 2'b01, e, m_rdata, w ? 0 : n, w ? n : 0, p ? x1 : x0, xd);
   endtask
   initial begin
      int guard, cnt;
      tbl[0] = '{2'b01, 1'b0, 32'h40, 32'h0, 32'h0, 32'hDEADBEEF, 3, 2'b01, 1'b0, 32'hDEADBEEF, 3, 0, 32'h40};
      tbl[1] = '{2'b10, 1'b1, 32'h0, 32'h80, 32'h12345678, 32'h0, 1, 2'b10, 1'b0, 32'hDEADBEEF, 0, 1, 32'h80};
      tbl[2] = '{2'b01, 1'b0, 32'h44, 32'h0, 32'h0, 32'h55555555, 0, 2'b01, 1'b1, 32'h0, 16, 0, 32'h44};
      tbl[3] = '{2'b10, 1'b0, 32'h0, 32'hC4, 32'h0, 32'hCAFEF00D, 2, 2'b10, 1'b0, 32'hCAFEF00D, 2, 0, 32'hC4};
      tbl[4] = '{2'b01, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0BADF00D, 16, 2'b01, 1'b0, 32'h0BADF00D, 16, 0, 32'h100};
      tbl[5] = '{2'b10, 1'b0, 32'h0, 32'h2C, 32'h0, 32'h77, 17, 2'b10, 1'b1, 32'h0, 16, 0, 32'h2C};
      tbl[6] = '{2'b10, 1'b1, 32'h0, 32'h3C, 32'hA5A5A5A5, 32'h0, 0, 2'b10, 1'b1, 32'h0, 0, 16, 32'h3C};
      repeat (2) @(negedge clk);
      chk("rst.done", DW'(done), DW'(0));
      chk("rst.err", DW'(err), DW'(0));
      chk("rst.rdata", rdata, DW'(0));
      chk("rst.mema", mema, DW'(0));
      chk("rst.memb", memb, DW'(0));
      chk("rst.rd", DW'(rd), DW'(0));
      chk("rst.wr", DW'(wrm), DW'(0));
      rst_n = 1'b1;
      ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_ack.strobe", DW'(rd | wrm), DW'(0));
         chk("idle_ack.done", DW'(done), DW'(0));
      end
      ack = 1'b0;
      idle(1);
      for (int i = 0; i < 7; i++) begin
         run_txn(tbl[i].req, tbl[i].w1, tbl[i].a0, tbl[i].a1, tbl[i].wd, tbl[i].ack_at, tbl[i].md);
         check_txn($sformatf("vec%0d", i), tbl[i].e_done, tbl[i].e_err, tbl[i].e_rdata,
                   tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_mema, tbl[i].wd);
      end
      req = 2'b00;
      idle(2);
      req = 2'b01; wr = 2'b00; a0 = 32'h200; ack = 1'b0;
      guard = 0; cnt = 0;
      while (cnt < 2 && guard < 10) begin
         tick();
         guard++;
         if (rd) cnt++;
      end
      chk("rstmid.reached", DW'(cnt), DW'(2));
      rst_n = 1'b0;
      #1;
      chk("rstmid.rd", DW'(rd), DW'(0));
      chk("rstmid.done", DW'(done), DW'(0));
      chk("rstmid.rdata", rdata, DW'(0));
      req = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstmid.no_done", DW'(done), DW'(0));
      end
      rst_n = 1'b1;
      after_done = 1'b0;
      m_last = 1'b1;
      m_rdata = '0;
      for (int i = 0; i < 4; i++)
         model_txn($sformatf("rr%0d", i), 2'b11, 1'b0, 32'h300 + DW'(i), 32'h400 + DW'(i), 32'h0, 1, 32'h1000 + DW'(i));
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            req = 2'b00;
            idle(1);
         end
         model_txn($sformatf("rnd%0d", i), 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 18), $urandom);
      end
      req = 2'b00;
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
